// File: rtl/shift_ser_ctrl.sv
// shift_ser_ctrl: loads words into a universal shift register and shifts them out one bit per cycle
module shift_ser_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] In_data,
  input  logic             Dir,
  input  logic             Fill,
  input  logic             Stall,
  input  logic [WIDTH-1:0] DataOut,
  output logic             S1,
  output logic             S0,
  output logic             L,
  output logic             R,
  output logic [WIDTH-1:0] Datain,
  output logic             Ser_out,
  output logic             Ser_valid,
  output logic             Frame,
  output logic             Done
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] gap_cnt;
  logic [WIDTH-1:0] word;
  logic dir;
  logic shifting, last;
  logic [WIDTH-1:0] pick;
  assign shifting = state == SHIFT && !Stall;
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state <= IDLE;
      cnt <= '0;
      gap_cnt <= '0;
      word <= '0;
      dir <= 1'b0;
    end else
      case (state)
        IDLE: if (In_valid) begin
          word <= In_data;
          dir <= Dir;
          state <= LOAD;
        end
        LOAD: begin
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: if (!Stall) begin
          cnt <= cnt + 1'b1;
          gap_cnt <= '0;
          if (last) state <= GAP_CYCLES == 0 ? IDLE : GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == 4'(GAP_CYCLES - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  // One-hot tap on the register's exit end for the captured direction
  assign pick = dir ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(1);
  assign Ser_out = |(DataOut & pick);
  assign In_ready = state == IDLE && !Rst;
  assign S1 = state == LOAD || (shifting && dir);
  assign S0 = state == LOAD || (shifting && !dir);
  assign L = Fill;
  assign R = Fill;
  assign Datain = word;
  assign Ser_valid = shifting;
  assign Frame = state == LOAD || state == SHIFT;
  assign Done = shifting && last;
endmodule

// File: tb/tb_shift_ser_ctrl.sv
// tb_shift_ser_ctrl: drives shift_ser_ctrl against a modelled 4-bit universal shift register
module tb_shift_ser_ctrl;
  logic Clk = 1'b0, Rst = 1'b1, In_valid = 1'b0, Dir = 1'b0, Fill = 1'b0, Stall = 1'b0;
  logic [3:0] In_data = '0;
  logic ready, s1, s0, l, r, ser_out, ser_valid, frame, done;
  logic ready0, s1_0, s0_0, l0, r0, ser_out0, ser_valid0, frame0, done0;
  logic [3:0] datain, datain0;
  logic [3:0] q = '0, q0 = '0;
  int passes = 0, total = 0;

  always #5 Clk = ~Clk;

  shift_ser_ctrl #(.WIDTH(4), .GAP_CYCLES(1)) dut (
    .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_ready(ready), .In_data(In_data),
    .Dir(Dir), .Fill(Fill), .Stall(Stall), .DataOut(q), .S1(s1), .S0(s0), .L(l), .R(r),
    .Datain(datain), .Ser_out(ser_out), .Ser_valid(ser_valid), .Frame(frame), .Done(done));

  shift_ser_ctrl #(.WIDTH(4), .GAP_CYCLES(0)) dut0 (
    .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_ready(ready0), .In_data(In_data),
    .Dir(Dir), .Fill(Fill), .Stall(Stall), .DataOut(q0), .S1(s1_0), .S0(s0_0), .L(l0), .R(r0),
    .Datain(datain0), .Ser_out(ser_out0), .Ser_valid(ser_valid0), .Frame(frame0), .Done(done0));

  function automatic logic [3:0] sreg(logic [3:0] cur, logic [1:0] m, logic li, logic ri, logic [3:0] d);
    return m == 2'b00 ? cur : m == 2'b01 ? {ri, cur[3:1]} : m == 2'b10 ? {cur[2:0], li} : d;
  endfunction

  always @(posedge Clk) begin
    q <= sreg(q, {s1, s0}, l, r, datain);
    q0 <= sreg(q0, {s1_0, s0_0}, l0, r0, datain0);
  end

  // Reference: the serial stream is the word read from the exit end, one bit per shift
  function automatic logic [3:0] model_seq(logic [3:0] d, logic dr);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = dr ? d[3-i] : d[i];
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic noise();
    In_valid = 1'($urandom);
    In_data = 4'($urandom);
    Dir = 1'($urandom);
  endtask

  task automatic run_word(input logic [3:0] data, input logic dr, input logic fl,
                          input logic [3:0] seq, input logic [15:0] smask, input int pct, input string tag);
    int n = 0, cyc = 0;
    @(negedge Clk);
    In_valid = 1'b1; In_data = data; Dir = dr; Fill = fl; Stall = 1'($urandom_range(1));
    #1 chk({tag, "_ready"}, ready, 1);
    @(negedge Clk);
    noise(); Stall = 1'($urandom_range(1));
    #1;
    chk({tag, "_load_mode"}, {s1, s0}, 2'b11);
    chk({tag, "_load_frame"}, {frame, ready, ser_valid}, 3'b100);
    chk({tag, "_load_datain"}, datain, data);
    while (n < 4 && cyc < 40) begin
      @(negedge Clk);
      noise(); Stall = smask[cyc[3:0]] || $urandom_range(99) < pct;
      #1 cyc++;
      if (Stall) begin
        chk({tag, "_stall_mode"}, {s1, s0}, 2'b00);
        chk({tag, "_stall_flags"}, {frame, ser_valid, done, ready}, 4'b1000);
      end else begin
        chk({tag, "_shift_mode"}, {s1, s0}, dr ? 2'b10 : 2'b01);
        chk({tag, "_shift_valid"}, {frame, ser_valid, ready}, 3'b110);
        chk({tag, "_bit"}, ser_out, seq[n]);
        chk({tag, "_done"}, done, n == 3);
        n++;
      end
    end
    if (n < 4) chk({tag, "_timeout"}, n, 4);
    @(negedge Clk);
    noise(); Stall = 1'($urandom_range(1));
    #1;
    chk({tag, "_gap_mode"}, {s1, s0}, 2'b00);
    chk({tag, "_gap_flags"}, {ready, frame, ser_valid, done}, 4'b0000);
    @(negedge Clk);
    In_valid = 1'b0; Stall = 1'($urandom_range(1));
    #1;
    chk({tag, "_idle_ready"}, {ready, frame, s1, s0}, 4'b1000);
    chk({tag, "_reg_fill"}, q, {4{fl}});
  endtask

  typedef struct {
    logic [3:0] data;
    logic dr;
    logic fl;
    logic [15:0] smask;
    logic [3:0] seq;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [12:0] er, ev, eb;
    tbl[0] = '{4'b1011, 1'b0, 1'b0, 16'h0000, 4'b1011};
    tbl[1] = '{4'b1011, 1'b1, 1'b1, 16'h0000, 4'b1101};
    tbl[2] = '{4'b0110, 1'b0, 1'b0, 16'h001C, 4'b0110};
    tbl[3] = '{4'b1001, 1'b1, 1'b0, 16'h0008, 4'b1001};
    tbl[4] = '{4'b0001, 1'b1, 1'b1, 16'h0005, 4'b1000};

    repeat (2) @(negedge Clk);
    #1;
    chk("rst_ready", {ready, ready0}, 2'b00);
    chk("rst_mode", {s1, s0}, 2'b00);
    chk("rst_datain", datain, 4'h0);
    chk("rst_flags", {ser_valid, frame, done}, 3'b000);
    @(negedge Clk);
    Rst = 1'b0;
    #1 chk("rst_release_ready", {ready, ready0}, 2'b11);

    for (int i = 0; i < 5; i++)
      run_word(tbl[i].data, tbl[i].dr, tbl[i].fl, tbl[i].seq, tbl[i].smask, 0, $sformatf("tbl%0d", i));

    // Asynchronous reset in the second shift cycle, away from any clock edge
    @(negedge Clk);
    In_valid = 1'b1; In_data = 4'b1010; Dir = 1'b0; Fill = 1'b0; Stall = 1'b0;
    @(negedge Clk);
    In_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #1 chk("arst_pre_frame", {frame, ser_valid}, 2'b11);
    #2 Rst = 1'b1;
    #1;
    chk("arst_flags", {ready, frame, ser_valid, done}, 4'b0000);
    chk("arst_mode", {s1, s0, datain}, 6'h00);
    @(negedge Clk);
    #1 chk("arst_hold_done", done, 0);
    Rst = 1'b0;
    #1 chk("arst_idle", {ready, frame}, 2'b10);
    run_word(4'b1010, 1'b0, 1'b0, 4'b1010, 16'h0000, 0, "post_rst");

    // GAP_CYCLES=0 instance with In_valid held high across two words
    er = 13'h1041; ev = 13'h0F3C; eb = 13'h0120;
    for (int c = 0; c < 13; c++) begin
      @(negedge Clk);
      In_valid = c < 12;
      In_data = c == 0 ? 4'b1000 : c <= 6 ? 4'b0001 : 4'($urandom);
      Dir = c <= 6 ? 1'b0 : 1'($urandom);
      Stall = 1'b0;
      #1;
      chk($sformatf("gap0_ready_c%0d", c), ready0, er[c]);
      chk($sformatf("gap0_valid_c%0d", c), ser_valid0, ev[c]);
      if (ev[c]) chk($sformatf("gap0_bit_c%0d", c), ser_out0, eb[c]);
    end
    In_valid = 1'b0;
    repeat (10) @(negedge Clk);

    for (int i = 0; i < 20; i++) begin
      logic [3:0] d;
      logic dr, fl;
      d = 4'($urandom); dr = 1'($urandom); fl = 1'($urandom);
      run_word(d, dr, fl, model_seq(d, dr), 16'h0000, 30, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
